// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: requester count,
// grant index width, FSM state encoding and the rotation mask helper.
package arb_pkg;

   localparam int NUM_REQ = 8;
   localparam int ID_W    = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Bits with index strictly above last_id: ~((2 << last_id) - 1).
   // Computed one bit wider so that last_id = NUM_REQ-1 yields an empty mask.
   function automatic logic [NUM_REQ-1:0] above_mask(input logic [ID_W-1:0] last_id);
      logic [NUM_REQ:0] below_s;
      below_s = ((NUM_REQ+1)'(2) << last_id) - (NUM_REQ+1)'(1);
      return ~below_s[NUM_REQ-1:0];
   endfunction

endpackage

// File: rtl/priority_encoder.sv
// Returns the position of the lowest set bit of req_vec (zero when none set).
module priority_encoder
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_vec,
   output logic [ID_W-1:0]    pos
);

   // Scan from MSB down so the lowest set bit is the last one written.
   always_comb begin
      pos = {ID_W{1'b0}};
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         pos = req_vec[i] ? ID_W'(i) : pos;
      end
   end

endmodule

// File: rtl/round_robin_arbiter.sv
// Eight-way round-robin arbiter with a single registered one-hot grant,
// done/withdraw release and a hold-time limit that forces release.
module round_robin_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
   output logic [ID_W-1:0]    grant_id,
   output logic               timeout
);

   localparam int              CNT_W    = $clog2(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

   arb_state_t        state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [ID_W-1:0]   last_r;

   logic [NUM_REQ-1:0] masked_s;
   logic [ID_W-1:0]    masked_pos_s;
   logic [ID_W-1:0]    plain_pos_s;
   logic [ID_W-1:0]    winner_s;
   logic               cur_req_s;
   logic               expire_s;
   logic               release_s;

   // Requesters after the last grantee get first pick; otherwise wrap around.
   always_comb begin
      masked_s = req & above_mask(last_r);
   end

   priority_encoder u_pe_masked (
      .req_vec (masked_s),
      .pos     (masked_pos_s)
   );

   priority_encoder u_pe_plain (
      .req_vec (req),
      .pos     (plain_pos_s)
   );

   // Pick the rotated winner when any requester lies above the pointer.
   always_comb begin
      if (masked_s != {NUM_REQ{1'b0}}) begin
         winner_s = masked_pos_s;
      end else begin
         winner_s = plain_pos_s;
      end
   end

   // Release conditions for the active grant.
   always_comb begin
      cur_req_s = req[grant_id];
      expire_s  = (cnt_r == CNT_LAST);
      release_s = done | ~cur_req_s | expire_s;
   end

   // Arbitration FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         grant       <= {NUM_REQ{1'b0}};
         grant_valid <= 1'b0;
         grant_id    <= {ID_W{1'b0}};
         timeout     <= 1'b0;
         cnt_r       <= {CNT_W{1'b0}};
         last_r      <= ID_W'(NUM_REQ - 1);
      end else begin
         case (state_r)
            IDLE: begin
               timeout <= 1'b0;
               if (req != {NUM_REQ{1'b0}}) begin
                  state_r     <= BUSY;
                  grant       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
                  grant_valid <= 1'b1;
                  grant_id    <= winner_s;
                  cnt_r       <= {CNT_W{1'b0}};
               end else begin
                  state_r <= IDLE;
               end
            end
            BUSY: begin
               if (release_s) begin
                  state_r     <= IDLE;
                  grant       <= {NUM_REQ{1'b0}};
                  grant_valid <= 1'b0;
                  last_r      <= grant_id;
                  cnt_r       <= {CNT_W{1'b0}};
                  // Only a pure hold-limit expiry is reported as a timeout.
                  timeout     <= expire_s & ~done & cur_req_s;
               end else begin
                  cnt_r   <= cnt_r + CNT_W'(1);
                  timeout <= 1'b0;
               end
            end
            default: begin
               state_r     <= IDLE;
               grant       <= {NUM_REQ{1'b0}};
               grant_valid <= 1'b0;
               timeout     <= 1'b0;
               cnt_r       <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

endmodule
